// File: rtl/parking_occupancy_tracker.sv
// Parking occupancy tracker.
// Keeps the parked/empty slot counts up to date from gate entry/exit pulses,
// accepts or refuses each event, flags full/empty, and runs an on-demand
// audit that serially popcounts a snapshot of the slot sensors and compares
// the result with the tracked count. Every output is registered.
//
// Handshake: there is no back-pressure. A request pulse sampled at a rising
// edge is always answered by exactly one response pulse (ack, nack or err)
// that is visible in the following cycle, together with the updated counts.
//
// Audit timing, with audit_start sampled at edge 0:
//   cycles 1..CAPACITY  SCAN     (one snapshot bit is added per cycle)
//   cycle  CAPACITY+1   COMPARE  (result is registered at the closing edge)
//   cycle  CAPACITY+2   audit_done pulse and audit_mismatch update
// audit_busy is high from cycle 1 through the audit_done cycle. audit_start
// is ignored for as long as audit_busy is high.
module parking_occupancy_tracker #(
    parameter int CAPACITY     = 8,
    parameter int CW           = 4,
    parameter int AUTO_CORRECT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enter_req,
    input  logic                exit_req,
    output logic                enter_ack,
    output logic                enter_nack,
    output logic                exit_ack,
    output logic                exit_err,
    input  logic [CAPACITY-1:0] slot_sensors,
    input  logic                audit_start,
    output logic                audit_busy,
    output logic                audit_done,
    output logic                audit_mismatch,
    output logic [CW-1:0]       parked_count,
    output logic [CW-1:0]       empty_count,
    output logic                lot_full,
    output logic                lot_empty
);

    // Lot size and final scan index, expressed at counter width.
    localparam logic [CW-1:0] CAP_C    = CW'(CAPACITY);
    localparam logic [CW-1:0] LAST_IDX = CW'(CAPACITY - 1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    // Audit FSM encoding.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SCAN    = 2'd1;
    localparam logic [1:0] S_COMPARE = 2'd2;

    // Audit state.
    logic [1:0]          state_q,    state_d;
    logic [CAPACITY-1:0] snap_q,     snap_d;
    logic [CW-1:0]       acc_q,      acc_d;
    logic [CW-1:0]       idx_q,      idx_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                mismatch_q, mismatch_d;

    // Occupancy state.
    logic [CW-1:0]       parked_q,   parked_d;
    logic [CW-1:0]       empty_q,    empty_d;
    logic                full_q,     full_d;
    logic                lempty_q,   lempty_d;

    // Response pulses.
    logic                enter_ack_q,  enter_ack_d;
    logic                enter_nack_q, enter_nack_d;
    logic                exit_ack_q,   exit_ack_d;
    logic                exit_err_q,   exit_err_d;

    // Shared decode between the audit FSM and the gate logic.
    logic                start_ok;
    logic                mismatch_now;
    logic                correcting;

    // A start is accepted only from a fully quiescent audit (not busy).
    assign start_ok     = audit_start && (state_q == S_IDLE) && !busy_q;
    // Popcount against the count held in the COMPARE cycle.
    assign mismatch_now = (acc_q != parked_q);
    // A correction overrides any gate event sampled in the same cycle.
    assign correcting   = (state_q == S_COMPARE) && (AUTO_CORRECT != 0) && mismatch_now;

    // Audit FSM: snapshot on start, shift/accumulate one bit per SCAN cycle, compare once.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    snap_d  = slot_sensors;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end else if (done_q) begin
                    // busy is held through the done cycle and released after it.
                    busy_d = 1'b0;
                end
            end
            S_SCAN: begin
                // The snapshot is shifted so the next bit is always at position 0.
                acc_d  = acc_q + CW'(snap_q[0]);
                snap_d = snap_q >> 1;
                idx_d  = idx_q + ONE_C;
                if (idx_q == LAST_IDX) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                mismatch_d = mismatch_now;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Gate events: accept/refuse entry and exit, or apply an audit correction.
    always_comb begin
        parked_d     = parked_q;
        enter_ack_d  = 1'b0;
        enter_nack_d = 1'b0;
        exit_ack_d   = 1'b0;
        exit_err_d   = 1'b0;
        if (correcting) begin
            parked_d     = acc_q;
            enter_nack_d = enter_req;
            exit_err_d   = exit_req;
        end else begin
            case ({enter_req, exit_req})
                2'b10: begin
                    if (parked_q < CAP_C) begin
                        enter_ack_d = 1'b1;
                        parked_d    = parked_q + ONE_C;
                    end else begin
                        enter_nack_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (parked_q != '0) begin
                        exit_ack_d = 1'b1;
                        parked_d   = parked_q - ONE_C;
                    end else begin
                        exit_err_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (parked_q == '0) begin
                        // Nothing to leave, but the entry still fits.
                        enter_ack_d = 1'b1;
                        exit_err_d  = 1'b1;
                        parked_d    = ONE_C;
                    end else begin
                        // The exit frees the slot the entry takes, even at full.
                        enter_ack_d = 1'b1;
                        exit_ack_d  = 1'b1;
                    end
                end
                default: begin
                    parked_d = parked_q;
                end
            endcase
        end
    end

    // Derived status, computed from the next count so it lands on the same edge.
    always_comb begin
        empty_d  = CAP_C - parked_d;
        full_d   = (parked_d == CAP_C);
        lempty_d = (parked_d == '0);
    end

    // State registers with synchronous active-low reset; reset aborts any audit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mismatch_q   <= 1'b0;
            parked_q     <= '0;
            empty_q      <= CAP_C;
            full_q       <= 1'b0;
            lempty_q     <= 1'b1;
            enter_ack_q  <= 1'b0;
            enter_nack_q <= 1'b0;
            exit_ack_q   <= 1'b0;
            exit_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mismatch_q   <= mismatch_d;
            parked_q     <= parked_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            lempty_q     <= lempty_d;
            enter_ack_q  <= enter_ack_d;
            enter_nack_q <= enter_nack_d;
            exit_ack_q   <= exit_ack_d;
            exit_err_q   <= exit_err_d;
        end
    end

    assign enter_ack      = enter_ack_q;
    assign enter_nack     = enter_nack_q;
    assign exit_ack       = exit_ack_q;
    assign exit_err       = exit_err_q;
    assign audit_busy     = busy_q;
    assign audit_done     = done_q;
    assign audit_mismatch = mismatch_q;
    assign parked_count   = parked_q;
    assign empty_count    = empty_q;
    assign lot_full       = full_q;
    assign lot_empty      = lempty_q;

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Bench for parking_occupancy_tracker (CAPACITY=8).
// Two instances share the stimulus: the main one with AUTO_CORRECT=1 and a
// second one with AUTO_CORRECT=0 whose parked count is checked alongside.
module tb_parking_occupancy_tracker;

    logic       clk;
    logic       rst_n;
    logic       enter_req;
    logic       exit_req;
    logic       audit_start;
    logic [7:0] slot_sensors;

    logic       enter_ack, enter_nack, exit_ack, exit_err;
    logic       audit_busy, audit_done, audit_mismatch;
    logic [3:0] parked_count, empty_count;
    logic       lot_full, lot_empty;

    logic       nc_enter_ack, nc_enter_nack, nc_exit_ack, nc_exit_err;
    logic       nc_audit_busy, nc_audit_done, nc_audit_mismatch;
    logic [3:0] nc_parked_count, nc_empty_count;
    logic       nc_lot_full, nc_lot_empty;

    // Flag fields of an expected vector: {ea, en, xa, xe, busy, done, mm}.
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_EA   = 7'b1000000;
    localparam logic [6:0] F_EN   = 7'b0100000;
    localparam logic [6:0] F_XA   = 7'b0010000;
    localparam logic [6:0] F_XE   = 7'b0001000;
    localparam logic [6:0] F_BUSY = 7'b0000100;
    localparam logic [6:0] F_DONE = 7'b0000010;
    localparam logic [6:0] F_MM   = 7'b0000001;

    logic [20:0] exp_q[$];
    int          n_vec;
    int          n_err;

    parking_occupancy_tracker #(.CAPACITY(8), .CW(4), .AUTO_CORRECT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .enter_req(enter_req), .exit_req(exit_req),
        .enter_ack(enter_ack), .enter_nack(enter_nack),
        .exit_ack(exit_ack), .exit_err(exit_err),
        .slot_sensors(slot_sensors), .audit_start(audit_start),
        .audit_busy(audit_busy), .audit_done(audit_done),
        .audit_mismatch(audit_mismatch),
        .parked_count(parked_count), .empty_count(empty_count),
        .lot_full(lot_full), .lot_empty(lot_empty)
    );

    parking_occupancy_tracker #(.CAPACITY(8), .CW(4), .AUTO_CORRECT(0)) u_dut_nc (
        .clk(clk), .rst_n(rst_n),
        .enter_req(enter_req), .exit_req(exit_req),
        .enter_ack(nc_enter_ack), .enter_nack(nc_enter_nack),
        .exit_ack(nc_exit_ack), .exit_err(nc_exit_err),
        .slot_sensors(slot_sensors), .audit_start(audit_start),
        .audit_busy(nc_audit_busy), .audit_done(nc_audit_done),
        .audit_mismatch(nc_audit_mismatch),
        .parked_count(nc_parked_count), .empty_count(nc_empty_count),
        .lot_full(nc_lot_full), .lot_empty(nc_lot_empty)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    // Expected vector: flags, full, empty, parked, empty_count, parked of the AUTO_CORRECT=0 lot.
    function automatic logic [20:0] mk(input logic [6:0] f, input int p, input int pnc);
        logic [3:0] pc;
        logic [3:0] ec;
        logic [3:0] nc;
        pc = 4'(p);
        ec = 4'(8 - p);
        nc = 4'(pnc);
        return {f, (p == 8), (p == 0), pc, ec, nc};
    endfunction

    // Driver: apply one cycle of inputs, then queue the response expected next cycle.
    task automatic step(input logic en, input logic ex, input logic st, input logic [7:0] sens,
                        input logic [6:0] f, input int p, input int pnc);
        enter_req    = en;
        exit_req     = ex;
        audit_start  = st;
        slot_sensors = sens;
        @(posedge clk);
        exp_q.push_back(mk(f, p, pnc));
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [6:0] f, input int p, input int pnc);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, f, p, pnc);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        enter_req    = 1'b0;
        exit_req     = 1'b0;
        audit_start  = 1'b0;
        slot_sensors = 8'h00;
        @(posedge clk);
        exp_q.push_back(mk(F_NONE, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard: every negedge with a pending expectation is one comparison.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            logic [20:0] a;
            e = exp_q.pop_front();
            a = {enter_ack, enter_nack, exit_ack, exit_err, audit_busy, audit_done,
                 audit_mismatch, lot_full, lot_empty, parked_count, empty_count,
                 nc_parked_count};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL vec%0d: got %b expected %b (ea en xa xe busy done mm full empty | parked | empty | nc_parked)",
                         n_vec, a, e);
            end
        end
    end

    // Stimulus.
    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        enter_req    = 1'b0;
        exit_req     = 1'b0;
        audit_start  = 1'b0;
        slot_sensors = 8'h00;
        @(negedge clk);
        do_reset();

        // Fill to capacity, then one refused entry.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 8'h00, F_EA, i, i);
        step(1'b1, 1'b0, 1'b0, 8'h00, F_EN, 8, 8);
        // Simultaneous at full: both acked, still full.
        step(1'b1, 1'b1, 1'b0, 8'h00, F_EA | F_XA, 8, 8);
        // Down to 3, simultaneous at 3.
        for (int i = 7; i >= 3; i--) step(1'b0, 1'b1, 1'b0, 8'h00, F_XA, i, i);
        step(1'b1, 1'b1, 1'b0, 8'h00, F_EA | F_XA, 3, 3);
        // Down to 0, refused exit, then simultaneous at 0.
        for (int i = 2; i >= 0; i--) step(1'b0, 1'b1, 1'b0, 8'h00, F_XA, i, i);
        step(1'b0, 1'b1, 1'b0, 8'h00, F_XE, 0, 0);
        step(1'b1, 1'b1, 1'b0, 8'h00, F_EA | F_XE, 1, 1);
        step(1'b0, 1'b1, 1'b0, 8'h00, F_XA, 0, 0);

        // Count 5, sensors 0001_0111 (popcount 4): mismatch, corrected to 4 only with AUTO_CORRECT.
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, 8'h00, F_EA, i, i);
        step(1'b0, 1'b0, 1'b1, 8'b0001_0111, F_BUSY, 5, 5);
        idle(8, F_BUSY, 5, 5);
        idle(1, F_BUSY | F_DONE | F_MM, 4, 5);
        idle(1, F_MM, 4, 5);

        // Entry during SCAN, second start ignored, entry refused at a correcting COMPARE.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, F_EA, 1, 1);
        step(1'b1, 1'b0, 1'b0, 8'h00, F_EA, 2, 2);
        step(1'b0, 1'b0, 1'b1, 8'b1111_0000, F_BUSY, 2, 2);
        step(1'b1, 1'b0, 1'b0, 8'h00, F_BUSY | F_EA, 3, 3);
        step(1'b0, 1'b0, 1'b1, 8'hFF, F_BUSY, 3, 3);
        idle(6, F_BUSY, 3, 3);
        step(1'b1, 1'b0, 1'b0, 8'h00, F_EN | F_BUSY | F_DONE | F_MM, 4, 4);
        idle(1, F_MM, 4, 4);

        // Matching audit: mismatch flag clears at done, exit in COMPARE processed normally.
        step(1'b0, 1'b0, 1'b1, 8'b0000_1111, F_BUSY | F_MM, 4, 4);
        idle(8, F_BUSY | F_MM, 4, 4);
        step(1'b0, 1'b1, 1'b0, 8'h00, F_XA | F_BUSY | F_DONE, 3, 3);
        idle(1, F_NONE, 3, 3);

        // Reset in mid-SCAN at count 6: no audit_done follows.
        do_reset();
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b0, 8'h00, F_EA, i, i);
        step(1'b0, 1'b0, 1'b1, 8'b0011_1111, F_BUSY, 6, 6);
        idle(3, F_BUSY, 6, 6);
        do_reset();
        idle(12, F_NONE, 0, 0);
        // A fresh audit then runs its full length (popcount 6 vs count 0).
        step(1'b0, 1'b0, 1'b1, 8'b0011_1111, F_BUSY, 0, 0);
        idle(8, F_BUSY, 0, 0);
        idle(1, F_BUSY | F_DONE | F_MM, 6, 0);
        idle(1, F_MM, 6, 0);

        // Drain and report.
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/parking_occupancy_tracker.md
Name: parking_occupancy_tracker

Overview:
- Sequential, parametrised successor to the lot's combinational empty-slot calculator.
- Tracks parked/empty counts for a lot of CAPACITY slots from gate entry/exit event pulses.
- Accepts or rejects each event, raises full/empty status, and runs an on-demand audit that serially popcounts the slot-sensor bitmap and compares it against the tracked count.
- Sits between the gate controllers and the display/billing logic.

Parameters:
- CAPACITY, 8, number of parking slots (1..255).
- CW, 4, counter width; must satisfy 2^CW > CAPACITY.
- AUTO_CORRECT, 1, when 1 an audit mismatch overwrites parked_count with the sensor popcount.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- enter_req  in  1  single-cycle pulse: car requests entry
- exit_req  in  1  single-cycle pulse: car reports exit
- enter_ack  out  1  pulse: entry accepted
- enter_nack  out  1  pulse: entry refused (lot full or audit correcting)
- exit_ack  out  1  pulse: exit accepted
- exit_err  out  1  pulse: exit refused (count already 0 or audit correcting)
- slot_sensors  in  CAPACITY  1 = slot occupied
- audit_start  in  1  pulse: begin audit
- audit_busy  out  1  high while audit in progress
- audit_done  out  1  one-cycle pulse at audit completion
- audit_mismatch  out  1  result of last audit; held until next audit_done
- parked_count  out  CW  cars currently parked
- empty_count  out  CW  CAPACITY - parked_count
- lot_full  out  1  parked_count == CAPACITY
- lot_empty  out  1  parked_count == 0

Behaviour:
- Reset (rst_n low at a rising edge): parked_count=0, empty_count=CAPACITY, lot_empty=1, lot_full=0; all ack/nack/err/done pulses 0; audit_busy=0, audit_mismatch=0; FSM=IDLE. Reset mid-audit aborts the audit with no audit_done.
- All outputs are registered. A request sampled at edge N produces its ack/nack/err and the updated counts after edge N; the response is visible in cycle N+1.
- The two count outputs are updated on the same edge, so empty_count + parked_count == CAPACITY always.
- enter_req alone: if parked_count < CAPACITY, ack and increment; else nack, no change.
- exit_req alone: if parked_count > 0, ack and decrement; else exit_err, no change.
- Simultaneous enter_req and exit_req:
  - count in 1..CAPACITY-1, or count == CAPACITY: both acked, count unchanged. The exit frees the slot the entry takes, so no nack at full.
  - count == 0: exit_err plus enter_ack, count becomes 1.
- Requests held high for k cycles are k independent events.
- Audit FSM, states IDLE, SCAN, COMPARE:
  - IDLE: on audit_start, snapshot slot_sensors into an internal register, clear the accumulator and bit index, go to SCAN. audit_busy rises the cycle after audit_start.
  - SCAN: add one snapshot bit (index 0 upward) per cycle. After exactly CAPACITY cycles go to COMPARE. Gate events continue to be processed normally.
  - COMPARE (one cycle): audit_mismatch <= (popcount != parked_count as of this cycle), audit_done pulse, then IDLE; audit_busy drops with audit_done.
  - If AUTO_CORRECT=1 and there is a mismatch: parked_count <= popcount, and any enter_req/exit_req sampled in this cycle is refused (enter_nack / exit_err), because the correction has priority.
  - If there is a match, or AUTO_CORRECT=0: events in the COMPARE cycle are processed normally.
- audit_start while audit_busy is ignored; the audit is not restarted.
- Latency from audit_start to audit_done is CAPACITY+2 cycles (audit_start at cycle 0, audit_done at cycle CAPACITY+2).
- Counters never wrap: the full/empty guards prevent it, and the popcount is ≤ CAPACITY by construction.

Test Plan:
- Reset, then 8 enter_req pulses on consecutive cycles (CAPACITY=8): 8 enter_ack, parked_count 8, empty_count 0, lot_full=1. A 9th enter_req gets enter_nack and the count stays 8.
- At count 0: exit_req gives exit_err, count stays 0, lot_empty=1. Then enter_req and exit_req in the same cycle give enter_ack + exit_err and count 1.
- At count 8: simultaneous enter_req+exit_req give both acks, count stays 8, lot_full stays 1. At count 3 the same stimulus gives both acks and count stays 3.
- Count 5, slot_sensors=8'b0001_0111, audit_start: audit_busy for 10 cycles; audit_done 10 cycles after audit_start; audit_mismatch=1; with AUTO_CORRECT=1, parked_count=4 and empty_count=4. Repeat with AUTO_CORRECT=0: count stays 5.
- Audit during which enter_req is pulsed in the SCAN phase: the event is acked and the count is incremented. An enter_req coinciding with a mismatching COMPARE (AUTO_CORRECT=1) gets enter_nack and the final count equals the popcount. A second audit_start during busy has no effect.
- rst_n low for 1 cycle in mid-SCAN at count 6: outputs return to reset values next cycle, no audit_done. A following audit_start runs a full CAPACITY+2-cycle audit.
